// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: execute/decode-queue inputs and fetch_unit/decode control outputs of the fetch sequencer
interface fetch_sequencer_if #(parameter int ADDR_W = 16);
  logic              ex_br_valid;
  logic              ex_br_taken;
  logic [ADDR_W-1:0] ex_br_target;
  logic [1:0]        dq_free;
  logic              dep_hazard;
  logic              halt_req;
  logic              fetch_stall;
  logic              fetch_branch_taken;
  logic [ADDR_W-1:0] fetch_branch_target;
  logic              fetch_single;
  logic [1:0]        fetch_valid;
  logic              flush;
  logic [1:0]        seq_state;
  modport master (
    output ex_br_valid, ex_br_taken, ex_br_target, dq_free, dep_hazard, halt_req,
    input  fetch_stall, fetch_branch_taken, fetch_branch_target, fetch_single, fetch_valid, flush, seq_state
  );
  modport slave (
    input  ex_br_valid, ex_br_taken, ex_br_target, dq_free, dep_hazard, halt_req,
    output fetch_stall, fetch_branch_taken, fetch_branch_target, fetch_single, fetch_valid, flush, seq_state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: per-cycle advance/stall/redirect/single decision for the dual-wide fetch_unit, all outputs registered
// Optional saturating perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer #(
  parameter int ADDR_W           = 16,
  parameter int REDIRECT_BUBBLES = 1
`ifdef FETCH_PERF_CNT_EN
  , parameter int CNT_W          = 16
`endif
) (
  input logic clk,
  input logic reset,
  fetch_sequencer_if.slave bus
`ifdef FETCH_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_stall_cyc
  , output logic [CNT_W-1:0] perf_redirects
  , output logic [CNT_W-1:0] perf_single
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, REDIRECT = 2'd2, HALT = 2'd3} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic stall, stall_nx, taken, taken_nx, single, single_nx, flush, flush_nx;
  logic [ADDR_W-1:0] target, target_nx;
  logic [1:0] valid, valid_nx;
  logic br, free0, narrow;
  assign br     = bus.ex_br_valid & bus.ex_br_taken;
  assign free0  = bus.dq_free == 2'd0;
  assign narrow = bus.dq_free == 2'd1 || bus.dep_hazard;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      stall  <= 1'b1;
      taken  <= 1'b0;
      single <= 1'b0;
      flush  <= 1'b0;
      target <= '0;
      valid  <= 2'b00;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      stall  <= stall_nx;
      taken  <= taken_nx;
      single <= single_nx;
      flush  <= flush_nx;
      target <= target_nx;
      valid  <= valid_nx;
    end
  // A taken branch wins over everything in RUN and REDIRECT; HALT ignores all inputs.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    stall_nx  = stall;
    taken_nx  = 1'b0;
    flush_nx  = 1'b0;
    single_nx = single;
    target_nx = target;
    valid_nx  = valid;
    if (state == IDLE)
      state_nx = RUN;
    else if (state != HALT && br) begin
      state_nx  = REDIRECT;
      cnt_nx    = 3'(REDIRECT_BUBBLES);
      taken_nx  = 1'b1;
      flush_nx  = 1'b1;
      target_nx = bus.ex_br_target;
      stall_nx  = 1'b0;
      single_nx = 1'b0;
      valid_nx  = 2'b00;
    end else if (state == REDIRECT) begin
      stall_nx  = 1'b0;
      single_nx = 1'b0;
      valid_nx  = 2'b00;
      cnt_nx    = cnt - 3'd1;
      state_nx  = cnt <= 3'd1 ? RUN : REDIRECT;
    end else if (state == RUN) begin
      if (bus.halt_req) begin
        state_nx  = HALT;
        stall_nx  = 1'b1;
        single_nx = 1'b0;
        valid_nx  = 2'b00;
      end else begin
        stall_nx  = free0;
        single_nx = !free0 && narrow;
        valid_nx  = free0 ? 2'b00 : narrow ? 2'b01 : 2'b11;
      end
    end
  end
  assign bus.fetch_stall         = stall;
  assign bus.fetch_branch_taken  = taken;
  assign bus.fetch_branch_target = target;
  assign bus.fetch_single        = single;
  assign bus.fetch_valid         = valid;
  assign bus.flush               = flush;
  assign bus.seq_state           = state;
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      perf_stall_cyc <= '0;
      perf_redirects <= '0;
      perf_single    <= '0;
    end else begin
      if (stall && state != HALT && !(&perf_stall_cyc)) perf_stall_cyc <= perf_stall_cyc + CNT_W'(1);
      if (taken && !(&perf_redirects)) perf_redirects <= perf_redirects + CNT_W'(1);
      if (single && !(&perf_single)) perf_single <= perf_single + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed-vector bench for fetch_sequencer with REDIRECT_BUBBLES=2
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n = 0;
  int errs = 0;
  fetch_sequencer_if #(.ADDR_W(16)) bus ();
`ifdef FETCH_PERF_CNT_EN
  logic [3:0] perf_stall_cyc, perf_redirects, perf_single;
  fetch_sequencer #(.ADDR_W(16), .REDIRECT_BUBBLES(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .perf_stall_cyc(perf_stall_cyc), .perf_redirects(perf_redirects), .perf_single(perf_single));
`else
  fetch_sequencer #(.ADDR_W(16), .REDIRECT_BUBBLES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic br(input logic on, input logic [15:0] tgt);
    bus.ex_br_valid  = on;
    bus.ex_br_taken  = on;
    bus.ex_br_target = tgt;
  endtask
  initial begin
    br(1'b0, 16'h0);
    bus.dq_free    = 2'd2;
    bus.dep_hazard = 1'b0;
    bus.halt_req   = 1'b0;
    step();
    step();
    chk("rst_state", bus.seq_state, 0);
    chk("rst_stall", bus.fetch_stall, 1);
    chk("rst_valid", bus.fetch_valid, 0);
    chk("rst_taken", bus.fetch_branch_taken, 0);
    chk("rst_target", bus.fetch_branch_target, 0);
    chk("rst_single", bus.fetch_single, 0);
    chk("rst_flush", bus.flush, 0);
    reset = 1'b1;
    step();
    chk("idle_state", bus.seq_state, 1);
    chk("idle_stall", bus.fetch_stall, 1);
    chk("idle_valid", bus.fetch_valid, 0);
    step();
    chk("run_stall", bus.fetch_stall, 0);
    chk("run_valid", bus.fetch_valid, 3);
    br(1'b1, 16'h0004);
    step();
    br(1'b0, 16'h0);
    chk("pulse_taken", bus.fetch_branch_taken, 1);
    chk("pulse_target", bus.fetch_branch_target, 16'h0004);
    chk("pulse_flush", bus.flush, 1);
    chk("pulse_valid", bus.fetch_valid, 0);
    chk("pulse_state", bus.seq_state, 2);
    step();
    chk("bub1_taken", bus.fetch_branch_taken, 0);
    chk("bub1_flush", bus.flush, 0);
    chk("bub1_valid", bus.fetch_valid, 0);
    step();
    chk("bub2_valid", bus.fetch_valid, 0);
    chk("bub2_state", bus.seq_state, 1);
    step();
    chk("post_valid", bus.fetch_valid, 3);
    chk("hold_target", bus.fetch_branch_target, 16'h0004);
    bus.dq_free = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dq0_stall", bus.fetch_stall, 1);
      chk("dq0_valid", bus.fetch_valid, 0);
    end
    bus.dq_free = 2'd2;
    step();
    chk("dq0_release", bus.fetch_stall, 0);
    bus.dq_free = 2'd0;
    step();
    chk("dq0b_stall", bus.fetch_stall, 1);
    br(1'b1, 16'h1234);
    step();
    br(1'b0, 16'h0);
    chk("stallbr_taken", bus.fetch_branch_taken, 1);
    chk("stallbr_stall", bus.fetch_stall, 0);
    chk("stallbr_target", bus.fetch_branch_target, 16'h1234);
    step();
    step();
    step();
    chk("stallbr_resume", bus.fetch_stall, 1);
    bus.dq_free = 2'd2;
    bus.dep_hazard = 1'b1;
    step();
    chk("dep_single", bus.fetch_single, 1);
    chk("dep_valid", bus.fetch_valid, 1);
    chk("dep_stall", bus.fetch_stall, 0);
    bus.dq_free = 2'd1;
    bus.dep_hazard = 1'b0;
    step();
    chk("dq1_single", bus.fetch_single, 1);
    chk("dq1_valid", bus.fetch_valid, 1);
    bus.dq_free = 2'd3;
    step();
    chk("dq3_single", bus.fetch_single, 0);
    chk("dq3_valid", bus.fetch_valid, 3);
    bus.halt_req = 1'b1;
    br(1'b1, 16'h0BEE);
    step();
    bus.halt_req = 1'b0;
    br(1'b0, 16'h0);
    chk("hb_taken", bus.fetch_branch_taken, 1);
    chk("hb_state", bus.seq_state, 2);
    chk("hb_target", bus.fetch_branch_target, 16'h0BEE);
    br(1'b1, 16'h00BB);
    step();
    br(1'b0, 16'h0);
    chk("rebr_taken", bus.fetch_branch_taken, 1);
    chk("rebr_target", bus.fetch_branch_target, 16'h00BB);
    bus.halt_req = 1'b1;
    step();
    chk("rd_halt_ign", bus.seq_state, 2);
    step();
    bus.halt_req = 1'b0;
    chk("rd_back_run", bus.seq_state, 1);
    step();
    chk("rd_run_valid", bus.fetch_valid, 3);
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    chk("halt_state", bus.seq_state, 3);
    chk("halt_stall", bus.fetch_stall, 1);
    chk("halt_valid", bus.fetch_valid, 0);
    br(1'b1, 16'h5555);
    step();
    step();
    br(1'b0, 16'h0);
    chk("halt_br_taken", bus.fetch_branch_taken, 0);
    chk("halt_br_target", bus.fetch_branch_target, 16'h00BB);
    chk("halt_hold", bus.seq_state, 3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    bus.dq_free = 2'd0;
    for (int i = 0; i < 20; i++) step();
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall_sat", perf_stall_cyc, 4'hF);
`endif
    bus.dq_free = 2'd1;
    step();
    step();
    step();
`ifdef FETCH_PERF_CNT_EN
    chk("perf_single", perf_single, 2);
`endif
    bus.dq_free = 2'd2;
    br(1'b1, 16'h7777);
    step();
    br(1'b0, 16'h0);
    chk("mid_taken", bus.fetch_branch_taken, 1);
    br(1'b1, 16'h8888);
    #3;
    reset = 1'b0;
    #1;
    br(1'b0, 16'h0);
    chk("mid_state", bus.seq_state, 0);
    chk("mid_stall", bus.fetch_stall, 1);
    chk("mid_taken0", bus.fetch_branch_taken, 0);
    chk("mid_target", bus.fetch_branch_target, 0);
    chk("mid_flush", bus.flush, 0);
    chk("mid_valid", bus.fetch_valid, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_perf_stall", perf_stall_cyc, 0);
    chk("mid_perf_redir", perf_redirects, 0);
    chk("mid_perf_single", perf_single, 0);
`endif
    step();
    chk("mid_no_pulse", bus.fetch_branch_taken, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, errs);
    $finish;
  end
endmodule
